// File: rtl/fpu_arbiter_pkg.sv
// fpu_pkg: float format, status codes and arbiter state type shared by the FPU arbiter slice.
package fpu_pkg;
    localparam int EXP_W  = 6;
    localparam int MANT_W = 25;
    localparam int BIAS   = 31;

    localparam logic [3:0] ST_EXACT     = 4'b0001;
    localparam logic [3:0] ST_INEXACT   = 4'b1111;
    localparam logic [3:0] ST_OVERFLOW  = 4'b0011;
    localparam logic [3:0] ST_UNDERFLOW = 4'b0111;
    localparam logic [3:0] ST_TIMEOUT   = 4'b0000;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;
endpackage

// File: rtl/fpu_arbiter_if.sv
// fpu_arbiter_if: requester handshake, shared response bus and FPU core signals.
interface fpu_arbiter_if #(parameter int NUM_REQ = 4);
    logic [NUM_REQ-1:0]    req_valid, req_ready, rsp_valid;
    logic [NUM_REQ*32-1:0] req_op_a, req_op_b;
    logic [31:0]           rsp_data, fpu_op_a, fpu_op_b, fpu_data;
    logic [3:0]            rsp_status, fpu_status;
    logic                  fpu_start, fpu_done;

    modport master (
        output req_valid, req_op_a, req_op_b, fpu_done, fpu_data, fpu_status,
        input  req_ready, rsp_valid, rsp_data, rsp_status, fpu_start, fpu_op_a, fpu_op_b
    );
    modport slave (
        input  req_valid, req_op_a, req_op_b, fpu_done, fpu_data, fpu_status,
        output req_ready, rsp_valid, rsp_data, rsp_status, fpu_start, fpu_op_a, fpu_op_b
    );
endinterface

// File: rtl/fpu_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first set request at or above the pointer with wrap.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);
    always_comb begin
        any_o = |req_i;
        idx_o = '0;
        // scan downward so the closest requester above the pointer is written last
        for (int k = N - 1; k >= 0; k--) begin
            if (req_i[(int'(ptr_i) + k) % N]) idx_o = IW'((int'(ptr_i) + k) % N);
        end
        gnt_o = any_o ? (N'(1) << idx_o) : '0;
    end
endmodule

// File: rtl/fpu_arbiter.sv
// fpu_arbiter: round-robin scheduler sharing one multicycle FPU adder core among NUM_REQ requesters.
module fpu_arbiter
    import fpu_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input logic         clock,
    input logic         reset,
    fpu_arbiter_if.slave bus
);
    localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;

    arb_state_t         state_q, state_d;
    logic [IW-1:0]      ptr_q, ptr_d, grant_q, grant_d, win_idx;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        op_a_q, op_a_d, op_b_q, op_b_d, data_q, data_d;
    logic [3:0]         status_q, status_d;
    logic [NUM_REQ-1:0] win_oh;
    logic               win_any;

    rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
        .req_i(bus.req_valid),
        .ptr_i(ptr_q),
        .gnt_o(win_oh),
        .idx_o(win_idx),
        .any_o(win_any)
    );

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        cnt_d    = cnt_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        data_d   = data_q;
        status_d = status_q;
        case (state_q)
            IDLE: if (win_any) begin
                state_d = ISSUE;
                grant_d = win_idx;
                op_a_d  = bus.req_op_a[32*win_idx +: 32];
                op_b_d  = bus.req_op_b[32*win_idx +: 32];
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: if (bus.fpu_done) begin
                data_d   = bus.fpu_data;
                status_d = bus.fpu_status;
                state_d  = RESP;
            end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                data_d   = '0;
                status_d = ST_TIMEOUT;
                state_d  = RESP;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            RESP: begin
                ptr_d   = (grant_q == IW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            grant_q  <= '0;
            cnt_q    <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            data_q   <= '0;
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            cnt_q    <= cnt_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            data_q   <= data_d;
            status_q <= status_d;
        end
    end

    assign bus.req_ready  = (state_q == IDLE) ? win_oh : '0;
    assign bus.rsp_valid  = (state_q == RESP) ? (NUM_REQ'(1) << grant_q) : '0;
    assign bus.fpu_start  = (state_q == ISSUE);
    assign bus.fpu_op_a   = op_a_q;
    assign bus.fpu_op_b   = op_b_q;
    assign bus.rsp_data   = data_q;
    assign bus.rsp_status = status_q;
endmodule

// File: tb/tb_fpu_arbiter.sv
// tb_fpu_arbiter: table vectors, corner-case sequences and randomized ops against a round-robin model.
module tb_fpu_arbiter;
    localparam int NR  = 4;
    localparam int TMO = 64;

    logic clock = 0, reset = 1;
    int total = 0, bad = 0, ptr_m = 0;
    logic [31:0] opa [NR];
    logic [31:0] opb [NR];

    fpu_arbiter_if #(.NUM_REQ(NR)) b ();
    fpu_arbiter #(.NUM_REQ(NR), .TIMEOUT(TMO), .CNT_W(7)) dut (.clock(clock), .reset(reset), .bus(b));

    always #5 clock = ~clock;

    typedef struct {
        logic [NR-1:0] mask;
        int            lat;
        bit            sp;
        logic [31:0]   a, bb, d;
        logic [3:0]    st;
        int            ew, ecyc;
        logic [31:0]   edata;
        logic [3:0]    est;
    } vec_t;
    vec_t tbl [6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    function automatic int pick(input logic [NR-1:0] m, input int p);
        for (int k = 0; k < NR; k++) if (m[(p + k) % NR]) return (p + k) % NR;
        return -1;
    endfunction

    function automatic int resp_cycle(input int lat);
        return (lat >= 1 && lat <= TMO) ? lat + 2 : TMO + 2;
    endfunction

    // called at a negedge with the DUT idle; returns at the negedge after the response
    task automatic run_op(input string nm, input logic [NR-1:0] mask, input int lat, input bit sp,
                          input logic [31:0] d, input logic [3:0] st, input int ew, input int ecyc,
                          input logic [31:0] edata, input logic [3:0] est);
        int c = 0;
        bit early = 0;
        b.req_valid = mask;
        for (int i = 0; i < NR; i++) begin
            b.req_op_a[32*i +: 32] = opa[i];
            b.req_op_b[32*i +: 32] = opb[i];
        end
        #1 chk({nm, " ready"}, b.req_ready, NR'(1) << ew);
        while (c < ecyc && c < TMO + 10) begin
            @(negedge clock);
            c++;
            if (c == 1) b.req_valid = '0;
            b.fpu_done   = (lat > 0 && c == 1 + lat) || (sp && c == 1);
            b.fpu_data   = d;
            b.fpu_status = st;
            if (c == 1) begin
                chk({nm, " start"}, b.fpu_start, 1);
                chk({nm, " op_a"}, b.fpu_op_a, opa[ew]);
                chk({nm, " op_b"}, b.fpu_op_b, opb[ew]);
            end
            if (c == 2) chk({nm, " start_pulse"}, b.fpu_start, 0);
            if (c < ecyc && b.rsp_valid != '0) early = 1;
        end
        chk({nm, " no_early_rsp"}, early, 0);
        chk({nm, " rsp_valid"}, b.rsp_valid, NR'(1) << ew);
        chk({nm, " rsp_data"}, b.rsp_data, edata);
        chk({nm, " rsp_status"}, b.rsp_status, est);
        b.fpu_done = 0;
        @(negedge clock);
        chk({nm, " rsp_one_cycle"}, b.rsp_valid, 0);
        chk({nm, " rsp_hold"}, b.rsp_data, edata);
        ptr_m = (ew + 1) % NR;
    endtask

    initial begin
        bit seen;
        tbl[0] = '{4'b0001, 5, 0, 32'h3E000000, 32'h3E000000, 32'h40000000, 4'b0001, 0, 7, 32'h40000000, 4'b0001};
        tbl[1] = '{4'b0100, 3, 0, 32'h40000000, 32'hBE000000, 32'h3E000000, 4'b0001, 2, 5, 32'h3E000000, 4'b0001};
        tbl[2] = '{4'b0010, -1, 0, 32'h3F000000, 32'h3F000000, 32'h12345678, 4'b1111, 1, 66, 32'h0, 4'b0000};
        tbl[3] = '{4'b1000, 4, 1, 32'h41000000, 32'h3E800000, 32'h7E000000, 4'b0011, 3, 6, 32'h7E000000, 4'b0011};
        tbl[4] = '{4'b0100, 64, 0, 32'h01000000, 32'h81000000, 32'h00000001, 4'b0111, 2, 66, 32'h00000001, 4'b0111};
        tbl[5] = '{4'b0001, 1, 0, 32'h3E000000, 32'hBE000000, 32'h00ABCDEF, 4'b1111, 0, 3, 32'h00ABCDEF, 4'b1111};
        b.req_valid = '0; b.req_op_a = '0; b.req_op_b = '0;
        b.fpu_done = 0; b.fpu_data = '0; b.fpu_status = '0;
        for (int i = 0; i < NR; i++) begin opa[i] = '0; opb[i] = '0; end
        repeat (2) @(negedge clock);
        reset = 0;
        chk("reset ready", b.req_ready, 0);
        chk("reset rsp_valid", b.rsp_valid, 0);
        chk("reset rsp_data", b.rsp_data, 0);
        chk("reset rsp_status", b.rsp_status, 0);
        chk("reset start", b.fpu_start, 0);
        chk("reset op_a", b.fpu_op_a, 0);
        chk("reset op_b", b.fpu_op_b, 0);

        // a done while idle must not produce anything
        b.fpu_done = 1; b.fpu_data = 32'hDEADBEEF; b.fpu_status = 4'b1111;
        @(negedge clock);
        b.fpu_done = 0;
        seen = 0;
        repeat (3) begin
            @(negedge clock);
            if (b.rsp_valid != '0 || b.fpu_start) seen = 1;
        end
        chk("idle_done ignored", seen, 0);

        for (int t = 0; t < 6; t++) begin
            opa[tbl[t].ew] = tbl[t].a;
            opb[tbl[t].ew] = tbl[t].bb;
            run_op($sformatf("vec%0d", t), tbl[t].mask, tbl[t].lat, tbl[t].sp, tbl[t].d, tbl[t].st,
                   tbl[t].ew, tbl[t].ecyc, tbl[t].edata, tbl[t].est);
        end

        // reset while waiting on the core: operation abandoned
        opa[3] = 32'h5A5A5A5A; opb[3] = 32'hA5A5A5A5;
        b.req_valid = 4'b1000;
        b.req_op_a[96 +: 32] = opa[3];
        b.req_op_b[96 +: 32] = opb[3];
        #1 chk("rst_mid ready", b.req_ready, 4'b1000);
        @(negedge clock);
        b.req_valid = '0;
        repeat (8) @(negedge clock);
        reset = 1;
        @(negedge clock);
        reset = 0;
        chk("rst_mid rsp_data", b.rsp_data, 0);
        chk("rst_mid rsp_status", b.rsp_status, 0);
        chk("rst_mid op_a", b.fpu_op_a, 0);
        chk("rst_mid start", b.fpu_start, 0);
        seen = 0;
        repeat (TMO + 8) begin
            @(negedge clock);
            if (b.rsp_valid != '0 || b.fpu_start) seen = 1;
        end
        chk("rst_mid no_rsp", seen, 0);
        ptr_m = 0;

        // all requesters valid after reset: pointer restarts at 0
        for (int g = 0; g < 5; g++) begin
            for (int i = 0; i < NR; i++) begin opa[i] = 32'h1000 + i; opb[i] = 32'h2000 + g; end
            run_op($sformatf("rr%0d", g), 4'b1111, 2, 0, 32'h300 + g, 4'b0001,
                   g % NR, 4, 32'h300 + g, 4'b0001);
        end

        for (int r = 0; r < 40; r++) begin
            logic [NR-1:0] m;
            int lat, ew;
            logic [31:0] d;
            logic [3:0] st;
            m = NR'($urandom_range(1, (1 << NR) - 1));
            lat = $urandom_range(2, 9);
            d = $urandom;
            st = 4'($urandom);
            for (int i = 0; i < NR; i++) begin opa[i] = $urandom; opb[i] = $urandom; end
            ew = pick(m, ptr_m);
            run_op($sformatf("rnd%0d", r), m, lat, $urandom_range(0, 1) == 1, d, st,
                   ew, resp_cycle(lat), d, st);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
